// File: rtl/gain_fader_if.sv
// Sample stream bundle between the echo stage, the fader and the mixer.
// master drives samples and gain requests; slave is the fader.
interface gain_fader_if #(
   parameter int WIDTH      = 16,
   parameter int GAIN_WIDTH = 8
);
   logic                         sample_valid_in;
   logic signed [WIDTH-1:0]      data_in;
   logic [GAIN_WIDTH-1:0]        gain_target_in;
   logic                         mute_in;
   logic signed [WIDTH-1:0]      data_out;
   logic                         sample_valid_out;
   logic [GAIN_WIDTH-1:0]        gain_current_out;
   logic                         ramping_out;
   logic                         clip_out;

   modport master (
      output sample_valid_in, data_in, gain_target_in, mute_in,
      input  data_out, sample_valid_out, gain_current_out,
      input  ramping_out, clip_out
   );

   modport slave (
      input  sample_valid_in, data_in, gain_target_in, mute_in,
      output data_out, sample_valid_out, gain_current_out,
      output ramping_out, clip_out
   );
endinterface

// File: rtl/gain_fader.sv
// Per-track output gain with click-free ramped gain changes.
// Two-stage multiply / shift / saturate datapath, gain slews per sample.
module gain_fader #(
   parameter int WIDTH      = 16,
   parameter int GAIN_WIDTH = 8,
   parameter int RAMP_STEP  = 1
) (
   input logic         clk_in,
   input logic         rst_in,
   gain_fader_if.slave bus
);
   localparam int P = WIDTH + GAIN_WIDTH + 1;
   localparam logic [GAIN_WIDTH:0] STEP = (GAIN_WIDTH+1)'(RAMP_STEP);

   typedef enum logic [1:0] {MUTED, STEADY, RAMP_UP, RAMP_DOWN} state_t;

   state_t                  state, state_nx;
   logic [GAIN_WIDTH-1:0]   gain, gain_nx, tgt;
   logic [GAIN_WIDTH:0]     diff;
   logic                    ramp_r;

   logic signed [P-1:0]     a_ext, g_ext, prod_c, prod_r, s;
   logic [P-WIDTH:0]        hi;
   logic                    ovf;
   logic signed [WIDTH-1:0] sat_val;
   logic                    v1, v2, clip_r;
   logic signed [WIDTH-1:0] data_r;

   // Slew gain toward the effective target; next state follows new gain
   always_comb begin
      tgt      = bus.mute_in ? '0 : bus.gain_target_in;
      gain_nx  = gain;
      state_nx = state;
      diff     = '0;
      if (bus.sample_valid_in) begin
         unique case (1'b1)
            (gain < tgt): begin
               diff    = {1'b0, tgt} - {1'b0, gain};
               gain_nx = (diff <= STEP) ? tgt
                       : gain + STEP[GAIN_WIDTH-1:0];
            end
            (gain > tgt): begin
               diff    = {1'b0, gain} - {1'b0, tgt};
               gain_nx = (diff <= STEP) ? tgt
                       : gain - STEP[GAIN_WIDTH-1:0];
            end
            default: gain_nx = tgt;
         endcase
         unique case (1'b1)
            (gain_nx == tgt): state_nx = (tgt == '0) ? MUTED : STEADY;
            (gain_nx < tgt):  state_nx = RAMP_UP;
            default:          state_nx = RAMP_DOWN;
         endcase
      end
   end

   // Gain, state and ramp flag registers
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         state  <= MUTED;
         gain   <= '0;
         ramp_r <= 1'b0;
      end else begin
         state  <= state_nx;
         gain   <= gain_nx;
         ramp_r <= (state_nx == RAMP_UP) || (state_nx == RAMP_DOWN);
      end
   end

   // Full-width product using the gain before this sample's step
   always_comb begin
      a_ext  = {{(GAIN_WIDTH+1){bus.data_in[WIDTH-1]}}, bus.data_in};
      g_ext  = {{(WIDTH+1){1'b0}}, gain};
      prod_c = a_ext * g_ext;
   end

   // Stage 1 register: product and valid
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         prod_r <= '0;
         v1     <= 1'b0;
      end else begin
         v1 <= bus.sample_valid_in;
         if (bus.sample_valid_in) prod_r <= prod_c;
      end
   end

   // Floor-scale by unity and detect out-of-range results
   always_comb begin
      s       = prod_r >>> (GAIN_WIDTH-1);
      hi      = s[P-1:WIDTH-1];
      ovf     = !((&hi) || !(|hi));
      sat_val = s[P-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                       : {1'b0, {(WIDTH-1){1'b1}}};
   end

   // Stage 2 register: saturated sample, strobe and clip pulse
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         data_r <= '0;
         v2     <= 1'b0;
         clip_r <= 1'b0;
      end else begin
         v2     <= v1;
         clip_r <= v1 && ovf;
         if (v1) data_r <= ovf ? sat_val : s[WIDTH-1:0];
      end
   end

   assign bus.data_out         = data_r;
   assign bus.sample_valid_out = v2;
   assign bus.clip_out         = clip_r;
   assign bus.gain_current_out = gain;
   assign bus.ramping_out      = ramp_r;
endmodule

// File: tb/tb_gain_fader.sv
// Directed bench for gain_fader: ramps, unity, saturation,
// rounding, mute fades and asynchronous reset.
module tb_gain_fader;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   pass_cnt = 0;
   int   total_cnt = 0;

   gain_fader_if #(.WIDTH(16), .GAIN_WIDTH(8)) bus ();

   gain_fader #(.WIDTH(16), .GAIN_WIDTH(8), .RAMP_STEP(1)) dut (
      .clk_in (clk),
      .rst_in (rst),
      .bus    (bus.slave)
   );

   always #5 clk = ~clk;

   // One valid cycle driven from a negedge; returns one negedge later
   task automatic drive_sample(input logic signed [15:0] d,
                               input logic [7:0] g, input logic m);
      bus.sample_valid_in = 1'b1;
      bus.data_in         = d;
      bus.gain_target_in  = g;
      bus.mute_in         = m;
      @(negedge clk);
      bus.sample_valid_in = 1'b0;
   endtask

   task automatic test_reset;
      bus.sample_valid_in = 1'b0;
      bus.data_in         = '0;
      bus.gain_target_in  = '0;
      bus.mute_in         = 1'b0;
      rst = 1'b1;
      repeat (2) @(negedge clk);
      total_cnt++;
      if ({bus.data_out, bus.sample_valid_out, bus.gain_current_out,
           bus.ramping_out, bus.clip_out} !== '0)
         $display("FAIL reset_outputs got=%h want=0",
                  {bus.data_out, bus.sample_valid_out,
                   bus.gain_current_out, bus.ramping_out, bus.clip_out});
      else pass_cnt++;
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_ramp_up;
      int bad = 0;
      for (int i = 1; i <= 128; i++) begin
         drive_sample(16'sd0, 8'd128, 1'b0);
         if (bus.gain_current_out !== 8'(i)) bad++;
         if (bus.ramping_out !== (i < 128)) bad++;
         repeat (3) @(negedge clk);
      end
      total_cnt++;
      if (bad != 0) $display("FAIL ramp_up errors=%0d want=0", bad);
      else pass_cnt++;
      total_cnt++;
      if (bus.gain_current_out !== 8'd128 || bus.ramping_out !== 1'b0)
         $display("FAIL ramp_up_end gain=%0d ramp=%b want 128/0",
                  bus.gain_current_out, bus.ramping_out);
      else pass_cnt++;
   endtask

   task automatic test_unity;
      logic signed [15:0] vec [2];
      vec[0] = 16'sd1000;
      vec[1] = -16'sd32768;
      foreach (vec[k]) begin
         drive_sample(vec[k], 8'd128, 1'b0);
         total_cnt++;
         if (bus.sample_valid_out !== 1'b0)
            $display("FAIL unity_early k=%0d valid=%b want 0",
                     k, bus.sample_valid_out);
         else pass_cnt++;
         @(negedge clk);
         total_cnt++;
         if (bus.sample_valid_out !== 1'b1 || bus.data_out !== vec[k]
             || bus.clip_out !== 1'b0)
            $display("FAIL unity k=%0d v=%b d=%0d c=%b want 1/%0d/0",
                     k, bus.sample_valid_out, bus.data_out,
                     bus.clip_out, vec[k]);
         else pass_cnt++;
         @(negedge clk);
         total_cnt++;
         if (bus.sample_valid_out !== 1'b0 || bus.data_out !== vec[k])
            $display("FAIL unity_hold k=%0d v=%b d=%0d want 0/%0d",
                     k, bus.sample_valid_out, bus.data_out, vec[k]);
         else pass_cnt++;
      end
   endtask

   task automatic test_back_to_back;
      int bad = 0;
      for (int i = 129; i <= 255; i++) begin
         bus.sample_valid_in = 1'b1;
         bus.data_in         = 16'sd0;
         bus.gain_target_in  = 8'd255;
         bus.mute_in         = 1'b0;
         @(negedge clk);
         if (bus.gain_current_out !== 8'(i)) bad++;
         if (i > 130 && bus.sample_valid_out !== 1'b1) bad++;
      end
      bus.sample_valid_in = 1'b0;
      total_cnt++;
      if (bad != 0) $display("FAIL b2b_ramp errors=%0d want=0", bad);
      else pass_cnt++;
      repeat (3) @(negedge clk);
      total_cnt++;
      if (bus.gain_current_out !== 8'd255 || bus.ramping_out !== 1'b0)
         $display("FAIL b2b_end gain=%0d ramp=%b want 255/0",
                  bus.gain_current_out, bus.ramping_out);
      else pass_cnt++;
   endtask

   task automatic test_saturate;
      logic signed [15:0] din [3];
      logic signed [15:0] exp_d [3];
      logic               exp_c [3];
      din[0] = 16'sd20000;  exp_d[0] = 16'sd32767;  exp_c[0] = 1'b1;
      din[1] = -16'sd20000; exp_d[1] = -16'sd32768; exp_c[1] = 1'b1;
      din[2] = 16'sd100;    exp_d[2] = 16'sd199;    exp_c[2] = 1'b0;
      foreach (din[k]) begin
         drive_sample(din[k], 8'd255, 1'b0);
         @(negedge clk);
         total_cnt++;
         if (bus.sample_valid_out !== 1'b1 || bus.data_out !== exp_d[k]
             || bus.clip_out !== exp_c[k])
            $display("FAIL saturate k=%0d v=%b d=%0d c=%b want 1/%0d/%b",
                     k, bus.sample_valid_out, bus.data_out,
                     bus.clip_out, exp_d[k], exp_c[k]);
         else pass_cnt++;
         @(negedge clk);
         total_cnt++;
         if (bus.clip_out !== 1'b0)
            $display("FAIL clip_pulse k=%0d c=%b want 0", k, bus.clip_out);
         else pass_cnt++;
      end
   endtask

   task automatic test_rounding;
      int bad = 0;
      logic signed [15:0] din [2];
      logic signed [15:0] exp_d [2];
      for (int i = 254; i >= 64; i--) begin
         drive_sample(16'sd0, 8'd64, 1'b0);
         if (bus.gain_current_out !== 8'(i)) bad++;
      end
      total_cnt++;
      if (bad != 0) $display("FAIL ramp_down errors=%0d want=0", bad);
      else pass_cnt++;
      repeat (2) @(negedge clk);
      din[0] = -16'sd3; exp_d[0] = -16'sd2;
      din[1] = 16'sd3;  exp_d[1] = 16'sd1;
      foreach (din[k]) begin
         drive_sample(din[k], 8'd64, 1'b0);
         @(negedge clk);
         total_cnt++;
         if (bus.sample_valid_out !== 1'b1 || bus.data_out !== exp_d[k])
            $display("FAIL rounding k=%0d v=%b d=%0d want 1/%0d",
                     k, bus.sample_valid_out, bus.data_out, exp_d[k]);
         else pass_cnt++;
      end
   endtask

   task automatic test_mute;
      int bad = 0;
      int prev;
      int mute_bits;
      for (int i = 0; i < 64; i++) drive_sample(16'sd0, 8'd128, 1'b0);
      total_cnt++;
      if (bus.gain_current_out !== 8'd128)
         $display("FAIL mute_setup gain=%0d want 128", bus.gain_current_out);
      else pass_cnt++;
      prev = 128;
      for (int i = 1; i <= 68; i++) begin
         drive_sample(16'sd0, 8'd128, 1'b1);
         if (bus.gain_current_out !== 8'(128 - i)) bad++;
         if (prev - int'(bus.gain_current_out) > 1) bad++;
         if (bus.ramping_out !== 1'b1) bad++;
         prev = int'(bus.gain_current_out);
      end
      total_cnt++;
      if (bad != 0) $display("FAIL mute_fade errors=%0d want=0", bad);
      else pass_cnt++;
      total_cnt++;
      if (bus.gain_current_out !== 8'd60)
         $display("FAIL mute_reverse gain=%0d want 60", bus.gain_current_out);
      else pass_cnt++;
      bad = 0;
      mute_bits = 0;
      for (int i = 1; i <= 68; i++) begin
         drive_sample(16'sd0, 8'd128, 1'b0);
         if (bus.gain_current_out !== 8'(60 + i)) bad++;
         if (int'(bus.gain_current_out) - prev > 1) bad++;
         if (bus.ramping_out !== (i < 68)) bad++;
         prev = int'(bus.gain_current_out);
      end
      total_cnt++;
      if (bad != 0) $display("FAIL unmute_rise errors=%0d want=0", bad);
      else pass_cnt++;
      for (int i = 1; i <= 3; i++) begin
         drive_sample(16'sd0, 8'd200, 1'b1);
         if (bus.gain_current_out !== 8'(128 - i)) mute_bits++;
      end
      total_cnt++;
      if (mute_bits != 0)
         $display("FAIL mute_wins errors=%0d want=0", mute_bits);
      else pass_cnt++;
   endtask

   task automatic test_async_reset;
      int bad = 0;
      bus.sample_valid_in = 1'b1;
      bus.data_in         = 16'sd500;
      bus.gain_target_in  = 8'd128;
      bus.mute_in         = 1'b1;
      repeat (4) @(negedge clk);
      @(posedge clk);
      #2 rst = 1'b1;
      #1;
      total_cnt++;
      if ({bus.data_out, bus.sample_valid_out, bus.gain_current_out,
           bus.ramping_out, bus.clip_out} !== '0)
         $display("FAIL async_reset got=%h want=0",
                  {bus.data_out, bus.sample_valid_out,
                   bus.gain_current_out, bus.ramping_out, bus.clip_out});
      else pass_cnt++;
      @(negedge clk);
      bus.sample_valid_in = 1'b0;
      bus.mute_in         = 1'b0;
      rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         if (bus.sample_valid_out !== 1'b0) bad++;
      end
      total_cnt++;
      if (bad != 0) $display("FAIL flush_strobes count=%0d want=0", bad);
      else pass_cnt++;
      drive_sample(16'sd500, 8'd128, 1'b0);
      total_cnt++;
      if (bus.sample_valid_out !== 1'b0 || bus.gain_current_out !== 8'd1)
         $display("FAIL post_reset_early v=%b g=%0d want 0/1",
                  bus.sample_valid_out, bus.gain_current_out);
      else pass_cnt++;
      @(negedge clk);
      total_cnt++;
      if (bus.sample_valid_out !== 1'b1 || bus.data_out !== 16'sd0)
         $display("FAIL post_reset_first v=%b d=%0d want 1/0",
                  bus.sample_valid_out, bus.data_out);
      else pass_cnt++;
   endtask

   initial begin
      test_reset();
      test_ramp_up();
      test_unity();
      test_back_to_back();
      test_saturate();
      test_rounding();
      test_mute();
      test_async_reset();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end
endmodule
